reindeer_mem_arbiter: RTL

Parametrised N-port arbiter between Reindeer requesters (OCD, instruction fetch, data load/store, optional DMA) and one single-ported, byte-writable synchronous memory. It generalises the fixed three-source priority mux to NUM_PORTS requesters with a req/gnt handshake, memory wait states, a per-access timeout and per-port read-response routing. It sits between the core/OCD and the RAM or external memory controller.

---
 rtl/reindeer_mem_pkg.sv | 20 ++
 rtl/reindeer_mem_arb_pick.sv | 59 +++++
 rtl/reindeer_mem_arbiter.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/reindeer_mem_pkg.sv
// rtl/reindeer_mem_pkg.sv - shared state encoding, defaults and helpers for the Reindeer memory arbiter
package reindeer_mem_pkg;

    localparam int DEF_ADDR_BITS = 14;
    localparam int DEF_XLEN      = 32;

    // Widest byte-enable vector the read-detect helper accepts (XLEN up to 512).
    localparam int MAX_WE_BITS   = 64;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_e;

    // An access with no byte enables set is a read.
    function automatic logic we_is_read(input logic [MAX_WE_BITS-1:0] we);
        return (we == '0);
    endfunction

endpackage

// File: rtl/reindeer_mem_arb_pick.sv
// rtl/reindeer_mem_arb_pick.sv - combinational winner picker; REINDEER_MEM_ARB_RR_EN selects round-robin among ports 1..N-1
module reindeer_mem_arb_pick #(
    parameter int NUM_PORTS = 3,
    parameter int IDX_W     = $clog2(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] req_i,
    input  logic [IDX_W-1:0]     ptr_i,
    output logic [NUM_PORTS-1:0] win_o,
    output logic [IDX_W-1:0]     idx_o
);

    logic found;

`ifdef REINDEER_MEM_ARB_RR_EN
    int               cand;
    logic [IDX_W-1:0] cand_idx;

    // Port 0 first, then scan ports 1..N-1 cyclically starting at the pointer.
    always_comb begin
        idx_o    = '0;
        found    = 1'b0;
        cand     = 0;
        cand_idx = '0;
        if (req_i[0]) begin
            found = 1'b1;
        end else begin
            for (int k = 0; k < NUM_PORTS - 1; k++) begin
                cand = int'(ptr_i) + k;
                if (cand >= NUM_PORTS) begin
                    cand = cand - (NUM_PORTS - 1);
                end
                cand_idx = IDX_W'(cand);
                if (!found && req_i[cand_idx]) begin
                    found = 1'b1;
                    idx_o = cand_idx;
                end
            end
        end
    end
`else
    logic unused_ptr;
    assign unused_ptr = ^ptr_i;

    // Fixed priority: the lowest requesting index wins.
    always_comb begin
        idx_o = '0;
        found = 1'b0;
        for (int p = NUM_PORTS - 1; p >= 0; p--) begin
            if (req_i[p]) begin
                found = 1'b1;
                idx_o = IDX_W'(p);
            end
        end
    end
`endif

    assign win_o = found ? (NUM_PORTS'(1) << idx_o) : '0;

endmodule

// File: rtl/reindeer_mem_arbiter.sv
// rtl/reindeer_mem_arbiter.sv - N-port req/gnt arbiter onto one byte-writable memory; REINDEER_MEM_ARB_RR_EN enables round-robin
module reindeer_mem_arbiter
    import reindeer_mem_pkg::*;
#(
    parameter int NUM_PORTS = 3,
    parameter int ADDR_BITS = DEF_ADDR_BITS,
    parameter int XLEN      = DEF_XLEN,
    parameter int MAX_WAIT  = 15
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            sync_reset,
    input  logic [NUM_PORTS-1:0]            req,
    input  logic [NUM_PORTS*(XLEN/8)-1:0]   req_we,
    input  logic [NUM_PORTS*ADDR_BITS-1:0]  req_addr,
    input  logic [NUM_PORTS*XLEN-1:0]       req_wdata,
    output logic [NUM_PORTS-1:0]            gnt,
    output logic [NUM_PORTS-1:0]            rvalid,
    output logic [XLEN-1:0]                 rdata,
    output logic [NUM_PORTS-1:0]            err,
    output logic [ADDR_BITS-1:0]            mem_addr,
    output logic                            mem_read_en,
    output logic [XLEN/8-1:0]               mem_write_en,
    output logic [XLEN-1:0]                 mem_write_data,
    input  logic [XLEN-1:0]                 mem_read_data,
    input  logic                            mem_ready
);

    localparam int         XLEN_BYTES = XLEN / 8;
    localparam int         IDX_W      = $clog2(NUM_PORTS);
    localparam logic [7:0] LAST_WAIT  = 8'(MAX_WAIT - 1);

    arb_state_e            state_q;
    logic [IDX_W-1:0]      owner_q;
    logic [7:0]            wait_cnt_q;
    logic [NUM_PORTS-1:0]  rvalid_q;
    logic [NUM_PORTS-1:0]  rvalid_d;

    logic [IDX_W-1:0]      rr_ptr;
    logic [IDX_W-1:0]      pick_idx;
    logic [NUM_PORTS-1:0]  pick_win;
    logic [IDX_W-1:0]      sel_idx;
    logic [NUM_PORTS-1:0]  sel_hot;
    logic [XLEN_BYTES-1:0] sel_we;
    logic                  busy;
    logic                  sel_req;
    logic                  sel_read;
    logic                  active;
    logic                  timeout;

    reindeer_mem_arb_pick #(
        .NUM_PORTS (NUM_PORTS),
        .IDX_W     (IDX_W)
    ) u_pick (
        .req_i (req),
        .ptr_i (rr_ptr),
        .win_o (pick_win),
        .idx_o (pick_idx)
    );

    // In BUSY the owner keeps the memory; otherwise the picker's winner drives it.
    assign busy     = (state_q == ARB_BUSY);
    assign sel_idx  = busy ? owner_q : pick_idx;
    assign sel_hot  = busy ? (NUM_PORTS'(1) << owner_q) : pick_win;
    assign sel_req  = req[sel_idx];
    assign sel_we   = req_we[sel_idx*XLEN_BYTES +: XLEN_BYTES];
    assign sel_read = we_is_read(MAX_WE_BITS'(sel_we));

    // No access is presented while either reset is applied or the selected port is idle.
    assign active   = reset_n & ~sync_reset & sel_req;
    assign timeout  = busy & (wait_cnt_q == LAST_WAIT) & ~mem_ready;

    assign mem_addr       = req_addr[sel_idx*ADDR_BITS +: ADDR_BITS];
    assign mem_write_data = req_wdata[sel_idx*XLEN +: XLEN];
    assign mem_read_en    = active & sel_read;
    assign mem_write_en   = active ? sel_we : '0;

    assign gnt      = (active & mem_ready) ? sel_hot : '0;
    assign err      = (active & timeout) ? sel_hot : '0;
    assign rvalid_d = (active & mem_ready & sel_read) ? sel_hot : '0;
    assign rvalid   = rvalid_q;
    assign rdata    = mem_read_data;

`ifdef REINDEER_MEM_ARB_RR_EN
    logic [IDX_W-1:0] rr_ptr_q;
    logic [IDX_W-1:0] rr_ptr_d;

    // Point just past the last granted non-zero port, wrapping back to port 1.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (active && mem_ready && (sel_idx != '0)) begin
            rr_ptr_d = (sel_idx == IDX_W'(NUM_PORTS - 1)) ? IDX_W'(1) : sel_idx + IDX_W'(1);
        end
    end

    // Round-robin pointer register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr_q <= IDX_W'(1);
        end else if (sync_reset) begin
            rr_ptr_q <= IDX_W'(1);
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign rr_ptr = rr_ptr_q;
`else
    assign rr_ptr = IDX_W'(1);
`endif

    // Access FSM: hold the owner through wait states, leave on grant, timeout or dropped request.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ARB_IDLE;
            owner_q    <= '0;
            wait_cnt_q <= '0;
        end else if (sync_reset) begin
            state_q    <= ARB_IDLE;
            owner_q    <= '0;
            wait_cnt_q <= '0;
        end else begin
            case (state_q)
                ARB_IDLE: begin
                    if (active && !mem_ready) begin
                        state_q    <= ARB_BUSY;
                        owner_q    <= pick_idx;
                        wait_cnt_q <= '0;
                    end
                end
                ARB_BUSY: begin
                    if (!active || mem_ready || timeout) begin
                        state_q    <= ARB_IDLE;
                        wait_cnt_q <= '0;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 8'd1;
                    end
                end
                default: begin
                    state_q <= ARB_IDLE;
                end
            endcase
        end
    end

    // Read-response flag follows a read grant by one cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rvalid_q <= '0;
        end else if (sync_reset) begin
            rvalid_q <= '0;
        end else begin
            rvalid_q <= rvalid_d;
        end
    end

endmodule
